uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 2500000; inter-byte timeout in clk cycles (100 ms at 25 MHz).
REQ-002 Parameter TOBITS, default 22; width of the timeout counter; SHALL satisfy 2^TOBITS > TIMEOUT.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_dv  input  1  byte-side UART: received byte available.
REQ-006 rx_data  input  8  byte-side UART: received byte.
REQ-007 rx_rd  output  1  one-cycle pulse; pops the received byte.
REQ-008 tx_thre  input  1  byte-side UART: transmit holding register empty.
REQ-009 tx_wr  output  1  one-cycle pulse; loads tx_data into the transmitter.
REQ-010 tx_data  output  8  byte to transmit.
REQ-011 bus_req  output  1  bus cycle valid; request to own the memory bus.
REQ-012 addr  output  30  word address [31:2].
REQ-013 wdata  output  32  write data.
REQ-014 wstrb  output  4  byte write lanes; 4'b0000 means read.
REQ-015 rdata  input  32  read data, valid the cycle after a read address is presented (synchronous RAM).
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Command framing: 0x57 'W' + 4 address bytes + 4 data bytes; 0x52 'R' + 4 address bytes; all multi-byte fields little-endian (LSB first).
REQ-018 Address byte bits [1:0] of the first address byte SHALL be ignored; addr = assembled[31:2].
REQ-019 Byte accept: when rx_dv=1 in an accepting state (IDLE, ADDR, DATA), capture rx_data and pulse rx_rd; rx_dv SHALL be ignored in the cycle immediately after an rx_rd pulse.
REQ-020 States: IDLE, ADDR, DATA, WRITE, READ, RCAP, RESP.
REQ-021 IDLE: 'W' or 'R' -> ADDR with byte counter = 0; any other byte -> RESP with single response byte 0x15 (NAK).
REQ-022 ADDR: after the 4th byte -> DATA for 'W', -> READ for 'R'; DATA: after the 4th byte -> WRITE.
REQ-023 WRITE: exactly one cycle with bus_req=1, wstrb=4'b1111, addr and wdata valid; then RESP with single byte 0x06 (ACK).
REQ-024 READ: exactly one cycle with bus_req=1, wstrb=0; RCAP: capture rdata into a 32-bit response register; then RESP with 4 bytes, LSB first.
REQ-025 RESP: when tx_thre=1 and no tx_wr in the previous cycle, pulse tx_wr with the current byte; after the last byte -> IDLE.
REQ-026 Outside WRITE/READ: bus_req=0 and wstrb=0; addr/wdata hold their last values.
REQ-027 Timeout counter clears on every accepted byte and on entry to ADDR/DATA; counts in ADDR and DATA; on reaching TIMEOUT -> IDLE, no response, partial command discarded.
REQ-028 No timeout in IDLE, WRITE, READ, RCAP or RESP.
REQ-029 rx_dv arriving during WRITE/READ/RCAP/RESP SHALL be left pending (no rx_rd) and accepted as a new command once back in IDLE.
REQ-030 Byte counter is 2 bits and wraps 3->0 only on a state transition; it never wraps within a field.

Reset
REQ-031 On reset: state=IDLE, rx_rd=0, tx_wr=0, tx_data=0, bus_req=0, wstrb=0, addr=0, wdata=0, busy=0, counters=0.
REQ-032 Reset asserted mid-command or mid-response SHALL abort immediately; no further bus cycle or tx_wr.

Structure
REQ-033 Command/response codes (0x57, 0x52, 0x06, 0x15) and state encodings SHALL live in a shared package/include of constants.
REQ-034 The timeout counter SHALL be a sub-module, uart_timeout (clear, enable, expired), instantiated once.

Verification
REQ-035 'W',00,01,00,00,EF,BE,AD,DE -> one cycle bus_req=1, addr=30'h40 (0x100>>2), wdata=0xDEADBEEF, wstrb=4'hF; tx byte 0x06.
REQ-036 'R',00,01,00,00 with rdata=0x12345678 next cycle -> one read cycle, wstrb=0; tx bytes 78,56,34,12 in order, each gated by tx_thre.
REQ-037 Byte 0x41 in IDLE -> tx 0x15, no bus_req, return to IDLE.
REQ-038 'W',03,02 then silence with TIMEOUT=100 -> IDLE at cycle 100 after last byte, no bus_req, no tx_wr; next 'R' command completes normally.
REQ-039 Reset asserted during RESP after 2 of 4 read bytes -> no further tx_wr, all outputs at reset values next cycle.
REQ-040 rx_dv held high for 3 consecutive cycles with one byte -> exactly one rx_rd pulse per byte.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// Shared constants for the UART bus master: command/response codes and FSM state encoding.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_RCAP  = 3'd5,
    S_RESP  = 3'd6
  } state_e;

endpackage

// File: rtl/uart_bus_master_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and flags the final one.
module uart_timeout #(
  parameter int unsigned TIMEOUT = 2500000,
  parameter int unsigned TOBITS  = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TOBITS-1:0] LAST = TOBITS'(TIMEOUT - 1);

  logic [TOBITS-1:0] count_q, count_d;

  // expired marks the TIMEOUT-th waiting cycle, so the owner leaves on the edge where the count would reach TIMEOUT
  assign expired = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes 'W'/'R' byte commands into single bus cycles and answers over the UART.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2500000,
  parameter int unsigned TOBITS  = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_thre,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        bus_req,
  output logic [29:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic [31:0] shift_q, shift_d;
  logic [29:0] pend_addr_q, pend_addr_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic [1:0]  resp_last_q, resp_last_d;
  logic        rx_rd_q, rx_rd_d, rx_hold_q;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        accepting, accept;
  logic        to_clear, to_enable, to_expired;
  logic [31:0] full_word;

  assign accepting = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  // rx_dv is stale while rx_rd is high and in the cycle after, until the UART has really popped
  assign accept    = accepting && rx_dv && !rx_rd_q && !rx_hold_q;
  assign full_word = {rx_data, shift_q[31:8]};
  assign to_enable = (state_q == S_ADDR) || (state_q == S_DATA);
  assign to_clear  = accept ||
                     ((state_d != state_q) && ((state_d == S_ADDR) || (state_d == S_DATA)));

  uart_timeout #(
    .TIMEOUT(TIMEOUT),
    .TOBITS (TOBITS)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_read_d   = is_read_q;
    shift_d     = shift_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    resp_last_d = resp_last_q;
    rx_rd_d     = accept;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = 2'd0;
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            state_d   = S_ADDR;
            is_read_d = (rx_data == CMD_READ);
          end else begin
            state_d     = S_RESP;
            resp_d      = {24'h0, RSP_NAK};
            resp_last_d = 2'd0;
          end
        end
      end
      S_ADDR: begin
        if (accept) begin
          shift_d = full_word;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (is_read_q) begin
              state_d = S_READ;
              addr_d  = full_word[31:2];
            end else begin
              state_d     = S_DATA;
              pend_addr_d = full_word[31:2];
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (to_expired) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = full_word;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_WRITE;
            addr_d  = pend_addr_q;
            wdata_d = full_word;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (to_expired) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        resp_d      = {24'h0, RSP_ACK};
        resp_last_d = 2'd0;
        cnt_d       = 2'd0;
      end
      S_READ: begin
        state_d = S_RCAP;
      end
      S_RCAP: begin
        state_d     = S_RESP;
        resp_d      = rdata;
        resp_last_d = 2'd3;
        cnt_d       = 2'd0;
      end
      S_RESP: begin
        if (tx_thre && !tx_wr_q) begin
          tx_wr_d   = 1'b1;
          tx_data_d = resp_q[{cnt_q, 3'b000} +: 8];
          if (cnt_q == resp_last_q) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      is_read_q   <= 1'b0;
      shift_q     <= 32'h0;
      pend_addr_q <= 30'h0;
      addr_q      <= 30'h0;
      wdata_q     <= 32'h0;
      resp_q      <= 32'h0;
      resp_last_q <= 2'd0;
      rx_rd_q     <= 1'b0;
      rx_hold_q   <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_read_q   <= is_read_d;
      shift_q     <= shift_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      resp_last_q <= resp_last_d;
      rx_rd_q     <= rx_rd_d;
      rx_hold_q   <= rx_rd_q;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign rx_rd   = rx_rd_q;
  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign bus_req = (state_q == S_WRITE) || (state_q == S_READ);
  assign wstrb   = (state_q == S_WRITE) ? 4'hF : 4'h0;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: UART/RAM models plus a command-level scoreboard.
module tb_uart_bus_master;

  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned TOBITS  = 8;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        rx_dv   = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rd;
  logic        tx_thre = 1'b1;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata   = 32'h0;
  logic        busy;

  uart_bus_master #(
    .TIMEOUT(TIMEOUT),
    .TOBITS (TOBITS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx_dv  (rx_dv),
    .rx_data(rx_data),
    .rx_rd  (rx_rd),
    .tx_thre(tx_thre),
    .tx_wr  (tx_wr),
    .tx_data(tx_data),
    .bus_req(bus_req),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .rdata  (rdata),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isWrite;
    logic [29:0] addr;
    logic [31:0] data;
  } busOp_t;

  busOp_t      expBus[$];
  logic [31:0] readVals[$];
  logic [7:0]  expTx[$];
  logic [7:0]  rxQ[$];

  int checks      = 0;
  int errors      = 0;
  int bytesPushed = 0;
  int rxPulses    = 0;
  int txCount     = 0;
  int busCount    = 0;
  int popLag      = 0;
  int holdBusy    = 0;
  int holdPrev    = 0;
  bit          rdataPending = 1'b0;
  logic [31:0] rdataNext    = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    rxQ.push_back(b);
    bytesPushed++;
  endtask

  // One command per call; the first byte decides write, read (d is the RAM word returned) or junk (NAK).
  task automatic applyStimulus(input logic [7:0] first, input logic [31:0] a, input logic [31:0] d);
    busOp_t op;
    pushByte(first);
    if (first == 8'h57 || first == 8'h52) begin
      for (int i = 0; i < 4; i++) pushByte(a[8*i +: 8]);
      op.isWrite = (first == 8'h57);
      op.addr    = a[31:2];
      op.data    = d;
      expBus.push_back(op);
      if (first == 8'h57) begin
        for (int i = 0; i < 4; i++) pushByte(d[8*i +: 8]);
        expTx.push_back(8'h06);
      end else begin
        readVals.push_back(d);
        for (int i = 0; i < 4; i++) expTx.push_back(d[8*i +: 8]);
      end
    end else begin
      expTx.push_back(8'h15);
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (!(rxQ.size() == 0 && popLag == 0 && expTx.size() == 0 && expBus.size() == 0 && !busy)
           && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "Drained"}, 32'(n < budget), 32'd1);
    checkOutput({tag, "RxPulses"}, 32'(rxPulses), 32'(bytesPushed));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".rx_rd"},   32'(rx_rd),   32'd0);
    checkOutput({tag, ".tx_wr"},   32'(tx_wr),   32'd0);
    checkOutput({tag, ".tx_data"}, 32'(tx_data), 32'd0);
    checkOutput({tag, ".bus_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, ".wstrb"},   32'(wstrb),   32'd0);
    checkOutput({tag, ".addr"},    32'(addr),    32'd0);
    checkOutput({tag, ".wdata"},   wdata,        32'd0);
    checkOutput({tag, ".busy"},    32'(busy),    32'd0);
  endtask

  // UART receiver / transmitter, synchronous RAM and bus/tx scoreboard, all evaluated mid-cycle
  always @(negedge clk) begin
    busOp_t op;

    if (rdataPending) begin
      rdata        = rdataNext;
      rdataPending = 1'b0;
    end else begin
      rdata = $urandom;
    end

    if (bus_req) begin
      busCount++;
      checkOutput("busCycleExpected", 32'(expBus.size() > 0), 32'd1);
      if (expBus.size() > 0) begin
        op = expBus.pop_front();
        checkOutput("busWstrb", 32'(wstrb), op.isWrite ? 32'hF : 32'h0);
        checkOutput("busAddr", 32'(addr), 32'(op.addr));
        if (op.isWrite) checkOutput("busWdata", wdata, op.data);
      end
      if (wstrb == 4'h0) begin
        rdataNext    = (readVals.size() > 0) ? readVals.pop_front() : $urandom;
        rdataPending = 1'b1;
      end
    end else begin
      checkOutput("idleWstrb", 32'(wstrb), 32'd0);
    end

    if (tx_wr) begin
      txCount++;
      checkOutput("txWhenReady", 32'(tx_thre), 32'd1);
      checkOutput("txNoOverrun", 32'(holdBusy == 0), 32'd1);
      checkOutput("txExpected", 32'(expTx.size() > 0), 32'd1);
      if (expTx.size() > 0) checkOutput("txData", 32'(tx_data), 32'(expTx.pop_front()));
      holdBusy = $urandom_range(1, 5);
    end else if (holdBusy > 0) begin
      holdBusy--;
    end
    // thre follows the holding register one cycle late, like a registered UART status flag
    tx_thre  = (holdPrev == 0);
    holdPrev = holdBusy;

    // rx_dv keeps showing a popped byte for two more cycles before the FIFO advances
    if (popLag > 0) begin
      popLag--;
      if (popLag == 0) begin
        checkOutput("rxPopHasByte", 32'(rxQ.size() > 0), 32'd1);
        if (rxQ.size() > 0) void'(rxQ.pop_front());
      end
    end
    if (rx_rd) begin
      rxPulses++;
      popLag = 2;
    end
    rx_dv   = (rxQ.size() > 0);
    rx_data = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  b;
    int          n;
    int          base;
    int          txBase;
    int          busBase;
    int          kind;

    repeat (3) tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();

    busBase = busCount;
    applyStimulus(8'h57, 32'h0000_0100, 32'hDEAD_BEEF);
    waitIdle("write", 500);
    checkOutput("writeOneBusCycle", 32'(busCount - busBase), 32'd1);
    checkOutput("writeAddrHeld", 32'(addr), 32'h40);
    checkOutput("writeDataHeld", wdata, 32'hDEAD_BEEF);

    busBase = busCount;
    txBase  = txCount;
    applyStimulus(8'h52, 32'h0000_0100, 32'h1234_5678);
    waitIdle("read", 500);
    checkOutput("readOneBusCycle", 32'(busCount - busBase), 32'd1);
    checkOutput("readTxBytes", 32'(txCount - txBase), 32'd4);
    checkOutput("readKeepsWdata", wdata, 32'hDEAD_BEEF);

    busBase = busCount;
    base    = rxPulses;
    applyStimulus(8'h41, 32'h0, 32'h0);
    waitIdle("nak", 200);
    checkOutput("nakNoBus", 32'(busCount - busBase), 32'd0);
    checkOutput("nakOnePulse", 32'(rxPulses - base), 32'd1);

    // Partial write, then silence: the FSM waits TIMEOUT full cycles after the accepting cycle
    busBase = busCount;
    txBase  = txCount;
    base    = rxPulses + 3;
    pushByte(8'h57);
    pushByte(8'h03);
    pushByte(8'h02);
    n = 0;
    while (rxPulses < base && n < 200) begin
      tick();
      n++;
    end
    checkOutput("toBytesAccepted", 32'(rxPulses), 32'(base));
    repeat (TIMEOUT - 1) tick();
    checkOutput("toStillBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("toIdle", 32'(busy), 32'd0);
    repeat (5) tick();
    checkOutput("toNoBus", 32'(busCount - busBase), 32'd0);
    checkOutput("toNoTx", 32'(txCount - txBase), 32'd0);
    applyStimulus(8'h52, $urandom, $urandom);
    waitIdle("afterTimeout", 500);

    // Back-to-back random commands; later bytes sit pending while earlier ones run their bus cycle and reply
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      d    = $urandom;
      if (kind == 0) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
        applyStimulus(b, a, d);
      end else if (kind == 1) begin
        applyStimulus(8'h57, a, d);
      end else begin
        applyStimulus(8'h52, a, d);
      end
    end
    waitIdle("random", 8000);

    txBase = txCount;
    applyStimulus(8'h52, $urandom, $urandom);
    n = 0;
    while (txCount < txBase + 2 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("midRespTwoBytes", 32'(txCount - txBase), 32'd2);
    reset = 1'b1;
    expTx.delete();
    tick();
    checkResetState("midReset");
    reset = 1'b0;
    repeat (20) tick();
    checkOutput("midResetNoMoreTx", 32'(txCount - txBase), 32'd2);
    checkOutput("midResetIdle", 32'(busy), 32'd0);

    applyStimulus(8'h57, $urandom, $urandom);
    waitIdle("recover", 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
